// File: rtl/decode_hazard_stage.sv
// Decode stage: hazard detection, in-ID branch resolution,
// squash of the branch shadow slot and the ID/EX register.
module decode_hazard_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_id_valid,
  input  logic [31:0]      if_id_instruc,
  input  logic [XLEN-1:0]  if_id_nextpc,
  input  logic             ctl_writereg,
  input  logic             ctl_readmem,
  input  logic             ctl_writemem,
  input  logic             ctl_regdst,
  input  logic             ctl_usesrb,
  input  logic [1:0]       ctl_extmode,
  input  logic [1:0]       ctl_branch,
  output logic [4:0]       id_reg_addra,
  output logic [4:0]       id_reg_addrb,
  input  logic [XLEN-1:0]  reg_id_dataa,
  input  logic [XLEN-1:0]  reg_id_datab,
  input  logic             ex_id_writereg,
  input  logic             ex_id_readmem,
  input  logic [4:0]       ex_id_regdest,
  input  logic             mem_id_writereg,
  input  logic             mem_id_readmem,
  input  logic [4:0]       mem_id_regdest,
  input  logic [XLEN-1:0]  mem_id_value,
  input  logic             ex_id_stall,
  output logic             id_if_stall,
  output logic             id_if_selpcsource,
  output logic [XLEN-1:0]  id_if_target,
  output logic             id_ex_valid,
  output logic             id_ex_writereg,
  output logic             id_ex_readmem,
  output logic             id_ex_writemem,
  output logic [XLEN-1:0]  id_ex_rega,
  output logic [XLEN-1:0]  id_ex_regb,
  output logic [XLEN-1:0]  id_ex_imedext,
  output logic [4:0]       id_ex_regdest,
  output logic [CNT_W-1:0] id_stall_cnt
);

  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic            is_br, is_jmp, use_rt, v;
  logic            m_ex, m_mem, haz, take;
  logic            fwd_a, fwd_b, eq;
  logic [XLEN-1:0] opa, opb;
  logic [XLEN-1:0] imm_sx, imm_zx, imm_ext;
  logic [XLEN-1:0] br_tgt, jmp_tgt;
  logic            squash_q, squash_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            unused_opcode;

  assign rs  = if_id_instruc[25:21];
  assign rt  = if_id_instruc[20:16];
  assign rd  = if_id_instruc[15:11];
  assign imm = if_id_instruc[15:0];
  assign unused_opcode = ^if_id_instruc[31:26];

  assign id_reg_addra = rs;
  assign id_reg_addrb = rt;

  assign is_br  = ctl_branch[1];
  assign is_jmp = (ctl_branch == 2'b01);
  assign use_rt = ctl_usesrb | is_br;
  assign v      = if_id_valid & ~squash_q;

  assign m_ex  = (ex_id_regdest != 5'd0) &
                 ((ex_id_regdest == rs) |
                  ((ex_id_regdest == rt) & use_rt));
  assign m_mem = (mem_id_regdest != 5'd0) &
                 ((mem_id_regdest == rs) |
                  ((mem_id_regdest == rt) & use_rt));

  assign haz = v & (
      (ex_id_readmem & ex_id_writereg & m_ex) |
      (is_br & ex_id_writereg & m_ex) |
      (is_br & mem_id_readmem & mem_id_writereg & m_mem));

  // forward a MEM-stage ALU result into the branch comparator
  assign fwd_a = mem_id_writereg & ~mem_id_readmem &
                 (mem_id_regdest != 5'd0) & (mem_id_regdest == rs);
  assign fwd_b = mem_id_writereg & ~mem_id_readmem &
                 (mem_id_regdest != 5'd0) & (mem_id_regdest == rt);
  assign opa = fwd_a ? mem_id_value : reg_id_dataa;
  assign opb = fwd_b ? mem_id_value : reg_id_datab;
  assign eq  = (opa == opb);

  assign imm_sx  = {{(XLEN-16){imm[15]}}, imm};
  assign imm_zx  = {{(XLEN-16){1'b0}}, imm};
  assign br_tgt  = if_id_nextpc + (imm_sx << 2);
  assign jmp_tgt = {if_id_nextpc[XLEN-1:28], if_id_instruc[25:0], 2'b00};

  // immediate extension select
  always_comb begin
    imm_ext = imm_sx;
    unique case (ctl_extmode)
      2'b01:   imm_ext = imm_zx;
      2'b10:   imm_ext = imm_zx << 16;
      default: imm_ext = imm_sx;
    endcase
  end

  // redirect decision and target select
  always_comb begin
    take = 1'b0;
    unique case (ctl_branch)
      2'b01:   take = 1'b1;
      2'b10:   take = eq;
      2'b11:   take = ~eq;
      default: take = 1'b0;
    endcase
    take = take & v & ~haz & ~ex_id_stall;
  end

  assign id_if_selpcsource = take;
  assign id_if_target      = is_jmp ? jmp_tgt : br_tgt;
  assign id_if_stall       = haz | ex_id_stall;

  // squash flag and saturating stall counter next state
  always_comb begin
    squash_d = squash_q;
    if (take)
      squash_d = 1'b1;
    else if (!id_if_stall)
      squash_d = 1'b0;
    cnt_d = cnt_q;
    if (haz && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // squash flag and stall counter state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      squash_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      squash_q <= squash_d;
      cnt_q    <= cnt_d;
    end
  end

  assign id_stall_cnt = cnt_q;

  // ID/EX register: hold on back-pressure, bubble on hazard or empty slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_valid    <= 1'b0;
      id_ex_writereg <= 1'b0;
      id_ex_readmem  <= 1'b0;
      id_ex_writemem <= 1'b0;
      id_ex_rega     <= '0;
      id_ex_regb     <= '0;
      id_ex_imedext  <= '0;
      id_ex_regdest  <= '0;
    end else if (!ex_id_stall) begin
      id_ex_valid    <= v & ~haz;
      id_ex_writereg <= v & ~haz & ctl_writereg;
      id_ex_readmem  <= v & ~haz & ctl_readmem;
      id_ex_writemem <= v & ~haz & ctl_writemem;
      id_ex_rega     <= reg_id_dataa;
      id_ex_regb     <= reg_id_datab;
      id_ex_imedext  <= imm_ext;
      id_ex_regdest  <= ctl_regdst ? rd : rt;
    end
  end

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised instruction-decode stage for the pinca-puca MIPS pipeline, sitting between the IF/ID and ID/EX boundaries. Over the current decode stage it adds:
- load-use and branch-operand hazard detection with bubble insertion;
- MEM-stage forwarding into the in-ID branch comparator;
- squashing of the instruction behind a taken branch or jump;
- downstream stall back-pressure;
- a saturating stall counter.

Control decode (opcode/funct) stays in the existing control unit and arrives as `ctl_*` inputs.

## Interface
Parameters:
- XLEN, 32, datapath/PC width; legal values ≥ 32.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_instruc  in  32  instruction word.
- if_id_nextpc  in  XLEN  PC+4 of that instruction.
- ctl_writereg / ctl_readmem / ctl_writemem  in  1 each  control unit outputs.
- ctl_regdst  in  1  1 = rd [15:11], 0 = rt [20:16].
- ctl_usesrb  in  1  instruction reads rt as a source.
- ctl_extmode  in  2  00 sign, 01 zero, 10 upper (imm<<16), 11 sign.
- ctl_branch  in  2  00 none, 01 jump, 10 beq, 11 bne.
- id_reg_addra / id_reg_addrb  out  5  = instr[25:21] / instr[20:16], combinational.
- reg_id_dataa / reg_id_datab  in  XLEN  register file read data. The register file is write-through.
- ex_id_writereg, ex_id_readmem  in  1  state of the instruction in EX.
- ex_id_regdest  in  5  destination register of the instruction in EX.
- mem_id_writereg, mem_id_readmem  in  1  state of the instruction in MEM.
- mem_id_regdest  in  5  destination register of the instruction in MEM.
- mem_id_value  in  XLEN  ALU result held in MEM.
- ex_id_stall  in  1  EX cannot accept; ID/EX must hold.
- id_if_stall  out  1  IF/ID and PC must hold.
- id_if_selpcsource  out  1  redirect PC to id_if_target.
- id_if_target  out  XLEN  branch or jump target.
- id_ex_valid, id_ex_writereg, id_ex_readmem, id_ex_writemem  out  1  registered.
- id_ex_rega, id_ex_regb, id_ex_imedext  out  XLEN  registered.
- id_ex_regdest  out  5  registered.
- id_stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation

Effective valid:
- v = if_id_valid & !squash.
- squash is an internal flop.

Source match:
- A register r "matches" when r != 0 and r == instr[25:21].
- It also matches on r == instr[20:16], but only when ctl_usesrb or ctl_branch ∈ {10, 11}.

Hazard stall (haz), asserted when v and any of:
- (a) ex_id_readmem & ex_id_writereg & ex_id_regdest matches (load-use).
- (b) ctl_branch ∈ {10, 11} & ex_id_writereg & ex_id_regdest matches.
- (c) ctl_branch ∈ {10, 11} & mem_id_readmem & mem_id_writereg & mem_id_regdest matches.

Branch comparator operands, per source:
- mem_id_value if mem_id_writereg & !mem_id_readmem & mem_id_regdest equals that source (≠0).
- Otherwise register file data.

Targets, all arithmetic mod 2^XLEN:
- Branch: nextpc + (sext(imm16) << 2).
- Jump: {nextpc[XLEN-1:28], instr[25:0], 2'b00}.

Redirect:
- take = v & !haz & !ex_id_stall & (jump | beq&eq | bne&!eq).
- id_if_selpcsource = take.

Stall to IF: id_if_stall = haz | ex_id_stall.

Immediate extension per ctl_extmode:
- Sign: {(XLEN-16){i[15]}, i}.
- Zero: zero-fill upper bits.
- Upper: {zeros, i, 16'b0}.

ID/EX register, at each clock edge:
- ex_id_stall = 1: hold all id_ex_* outputs.
- Else haz or !v: load a bubble. id_ex_valid, id_ex_writereg, id_ex_readmem and id_ex_writemem go to 0; the data fields are don't-care.
- Else load: rega/regb = register file data, imedext, regdest per ctl_regdst, control bits, id_ex_valid = 1.

Squash flop:
- Set to 1 on an edge where take = 1.
- Cleared on the next edge where !id_if_stall.
- Held while id_if_stall.
- A squashed instruction produces a bubble and never redirects.

Stall counter:
- Increments on each edge where haz = 1.
- Saturates at all-ones.
- Not incremented by ex_id_stall alone.

## Timing
- Reset (reset = 0) asynchronously clears:
  - every id_ex_* output;
  - squash;
  - id_stall_cnt.
- Combinational outputs (id_reg_addr*, id_if_*) follow their inputs during reset; IF discards them.
- Decode-to-EX latency is 1 cycle.
- Branch resolution is 0 cycles: redirect in the same cycle as decode, with exactly one squashed slot after it.
- Load-use costs 1 bubble.
- Branch dependent on an EX ALU result: 1 bubble.
- Branch dependent on a load: 2 bubbles, first via (b) then via (c).
- ex_id_stall together with haz: the hold wins, and the counter still increments.
- Reset mid-stall: all state is cleared and the next cycle decodes normally.

## Test plan
- **Load-use:** `lw $3` in EX (ex_id_readmem=1, regdest=3), then ID `add $4,$3,$5` → id_if_stall=1 for 1 cycle, one bubble (id_ex_valid=0), id_stall_cnt=1.
- **Branch after load:** ID `beq $3,$0` with `lw $3` in EX → 2 stall cycles. In the third cycle mem_id_value is not used; register file data compares, and 0 gives take=1.
- **Taken branch with MEM forwarding:** MEM non-load writes $7=5, ID `bne $7,$0,+4` with nextpc=0x100 → selpcsource=1, target=0x110, the next instruction is squashed (bubble), squash clears afterwards.
- **Jump:** instr=0x08000040, nextpc=0x0040_0004 → target=0x0000_0100, one squash slot.
- **Immediates:** imm=0x8001 → sign 0xFFFF8001, zero 0x00008001, upper 0x80010000. With XLEN=64, sign gives 0xFFFFFFFFFFFF8001.
- **Back-pressure and reset:** ex_id_stall=1 for 3 cycles holds id_ex_* and leaves the counter unchanged. Asserting reset low mid-hold clears all id_ex_* outputs and id_stall_cnt immediately.
